regfile_wport_arbiter: RTL and testbench

//  Shares the single regfile write port between the in-order WB stage and an
//  out-of-band long-latency unit (LU: divider/CSR-side results). Buffers LU

---
 rtl/regfile_wport_arbiter.sv | 175 +++++++++++++++++
 tb/tb_regfile_wport_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wport_arbiter.sv
`default_nettype none
// ============================================================================
// regfile_wport_arbiter
//   Arbitrates the single regfile write port between the WB stage and a
//   buffered long-latency unit, and keeps a scoreboard of pending LU writes.
//   Optional build macro RF_WPORT_STATS_EN adds stat_conflict_o/stat_hold_o.
//   Revision: 1.0
// ============================================================================
module regfile_wport_arbiter #(
   parameter int FIFO_DEPTH = 2,
   parameter int STARVE_MAX = 8
) (
   input  logic        clk,
   input  logic        start,
   input  logic        wb_regwrite_i,
   input  logic        wb_kill_i,
   input  logic [4:0]  wb_rd_i,
   input  logic [31:0] wb_wdata_i,
   input  logic        lu_valid_i,
   output logic        lu_ready_o,
   input  logic [4:0]  lu_rd_i,
   input  logic [31:0] lu_wdata_i,
   input  logic        issue_valid_i,
   input  logic [4:0]  issue_rd_i,
   input  logic [4:0]  rs1_d_i,
   input  logic [4:0]  rs2_d_i,
   output logic        rf_we_o,
   output logic [4:0]  rf_waddr_o,
   output logic [31:0] rf_wdata_o,
   output logic        wb_hold_o,
   output logic        stall_req_o,
`ifdef RF_WPORT_STATS_EN
   output logic [31:0] stat_conflict_o,
   output logic [15:0] stat_hold_o,
`endif
   output logic [31:0] pending_mask_o
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
   localparam logic [CW-1:0] DEPTH_CNT   = CW'(FIFO_DEPTH);
   localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);

   logic [4:0]    fifo_rd_q   [FIFO_DEPTH];
   logic [31:0]   fifo_data_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [SW-1:0] starve_q;
   logic          wb_hold_q;
   logic [31:0]   pending_q;
   logic [31:0]   pending_d;

   logic          fifo_empty;
   logic          fifo_full;
   logic          push;
   logic          pop;
   logic          wb_req;
   logic          starved;
   logic [4:0]    head_rd;
   logic [31:0]   head_data;
   logic          head_hit;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == DEPTH_CNT);
   assign lu_ready_o = !fifo_full;
   // Results aimed at x0 are consumed from the LU but never stored.
   assign push       = lu_valid_i && lu_ready_o && (lu_rd_i != 5'd0);
   assign wb_req     = wb_regwrite_i && !wb_kill_i && (wb_rd_i != 5'd0) && !wb_hold_q;
   assign pop        = !wb_req && !fifo_empty;
   assign starved    = !fifo_empty && !pop;
   assign head_rd    = fifo_rd_q[rd_ptr_q];
   assign head_data  = fifo_data_q[rd_ptr_q];

   always_comb begin
      rf_we_o    = 1'b0;
      rf_waddr_o = 5'd0;
      rf_wdata_o = 32'd0;
      if (wb_req) begin
         rf_we_o    = 1'b1;
         rf_waddr_o = wb_rd_i;
         rf_wdata_o = wb_wdata_i;
      end else if (!fifo_empty) begin
         rf_we_o    = 1'b1;
         rf_waddr_o = head_rd;
         rf_wdata_o = head_data;
      end
   end

   // Issue is applied after the pop clear so a newer op keeps its bit.
   always_comb begin
      pending_d = pending_q;
      if (pop) begin
         pending_d[head_rd] = 1'b0;
      end
      if (issue_valid_i && (issue_rd_i != 5'd0)) begin
         pending_d[issue_rd_i] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   assign head_hit    = !fifo_empty && !pop &&
                        ((head_rd == rs1_d_i) || (head_rd == rs2_d_i));
   assign stall_req_o = pending_q[rs1_d_i] | pending_q[rs2_d_i] | head_hit;

   assign wb_hold_o      = wb_hold_q;
   assign pending_mask_o = pending_q;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd_q[wr_ptr_q]   <= lu_rd_i;
         fifo_data_q[wr_ptr_q] <= lu_wdata_i;
      end
   end

   always_ff @(posedge clk or negedge start) begin
      if (!start) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         starve_q  <= '0;
         wb_hold_q <= 1'b0;
         pending_q <= 32'd0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         pending_q <= pending_d;

         // A hold cycle always grants the head, so holds cannot repeat back-to-back.
         wb_hold_q <= 1'b0;
         if (!starved) begin
            starve_q <= '0;
         end else if (starve_q == STARVE_LAST) begin
            starve_q  <= '0;
            wb_hold_q <= 1'b1;
         end else begin
            starve_q <= starve_q + SW'(1);
         end
      end
   end

`ifdef RF_WPORT_STATS_EN
   logic [31:0] stat_conflict_q;
   logic [15:0] stat_hold_q;

   always_ff @(posedge clk or negedge start) begin
      if (!start) begin
         stat_conflict_q <= 32'd0;
         stat_hold_q     <= 16'd0;
      end else begin
         if (!fifo_empty && wb_req && (stat_conflict_q != '1)) begin
            stat_conflict_q <= stat_conflict_q + 32'd1;
         end
         if (wb_hold_q && (stat_hold_q != '1)) begin
            stat_hold_q <= stat_hold_q + 16'd1;
         end
      end
   end

   assign stat_conflict_o = stat_conflict_q;
   assign stat_hold_o     = stat_hold_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wport_arbiter.sv
`default_nettype none
// ============================================================================
// tb_regfile_wport_arbiter
//   Directed self-checking bench for regfile_wport_arbiter (default params).
//   Revision: 1.0
// ============================================================================
module tb_regfile_wport_arbiter;

   logic        clk;
   logic        start;
   logic        wb_regwrite;
   logic        wb_kill;
   logic [4:0]  wb_rd;
   logic [31:0] wb_wdata;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_rd;
   logic [31:0] lu_wdata;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [4:0]  rs1_d;
   logic [4:0]  rs2_d;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        wb_hold;
   logic        stall_req;
   logic [31:0] pending_mask;
`ifdef RF_WPORT_STATS_EN
   logic [31:0] stat_conflict;
   logic [15:0] stat_hold;
`endif

   int total;
   int bad;

   regfile_wport_arbiter #(
      .FIFO_DEPTH (2),
      .STARVE_MAX (8)
   ) dut (
      .clk            (clk),
      .start          (start),
      .wb_regwrite_i  (wb_regwrite),
      .wb_kill_i      (wb_kill),
      .wb_rd_i        (wb_rd),
      .wb_wdata_i     (wb_wdata),
      .lu_valid_i     (lu_valid),
      .lu_ready_o     (lu_ready),
      .lu_rd_i        (lu_rd),
      .lu_wdata_i     (lu_wdata),
      .issue_valid_i  (issue_valid),
      .issue_rd_i     (issue_rd),
      .rs1_d_i        (rs1_d),
      .rs2_d_i        (rs2_d),
      .rf_we_o        (rf_we),
      .rf_waddr_o     (rf_waddr),
      .rf_wdata_o     (rf_wdata),
      .wb_hold_o      (wb_hold),
      .stall_req_o    (stall_req),
`ifdef RF_WPORT_STATS_EN
      .stat_conflict_o(stat_conflict),
      .stat_hold_o    (stat_hold),
`endif
      .pending_mask_o (pending_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the edge; checks happen 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      start       = 1'b0;
      wb_regwrite = 1'b0;
      wb_kill     = 1'b0;
      wb_rd       = 5'd0;
      wb_wdata    = 32'd0;
      lu_valid    = 1'b0;
      lu_rd       = 5'd0;
      lu_wdata    = 32'd0;
      issue_valid = 1'b0;
      issue_rd    = 5'd0;
      rs1_d       = 5'd0;
      rs2_d       = 5'd0;

      // Reset state
      tick(); tick();
      #1;
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_lu_ready", 32'(lu_ready), 32'd1);
      chk("rst_mask", pending_mask, 32'd0);
      chk("rst_hold", 32'(wb_hold), 32'd0);
      chk("rst_stall", 32'(stall_req), 32'd0);
      start = 1'b1;
      tick();
      #1;
      chk("idle_rf_we", 32'(rf_we), 32'd0);

      // Issue x5, then LU result for x5
      issue_valid = 1'b1; issue_rd = 5'd5; rs1_d = 5'd5;
      #1;
      chk("iss5_mask_before", pending_mask, 32'd0);
      tick();
      issue_valid = 1'b0;
      lu_valid = 1'b1; lu_rd = 5'd5; lu_wdata = 32'hDEAD_BEEF;
      #1;
      chk("iss5_mask_set", pending_mask, 32'h0000_0020);
      chk("iss5_stall", 32'(stall_req), 32'd1);
      chk("lu5_no_bypass", 32'(rf_we), 32'd0);
      tick();
      lu_valid = 1'b0;
      #1;
      chk("lu5_we", 32'(rf_we), 32'd1);
      chk("lu5_waddr", 32'(rf_waddr), 32'd5);
      chk("lu5_wdata", rf_wdata, 32'hDEAD_BEEF);
      chk("lu5_stall_popcyc", 32'(stall_req), 32'd1);
      chk("lu5_mask_popcyc", pending_mask, 32'h0000_0020);
      tick();
      #1;
      chk("lu5_mask_clr", pending_mask, 32'd0);
      chk("lu5_stall_clr", 32'(stall_req), 32'd0);
      chk("lu5_we_after", 32'(rf_we), 32'd0);
      rs1_d = 5'd0;

      // Starvation: WB writes every cycle while two LU results wait
      wb_regwrite = 1'b1; wb_rd = 5'd1; wb_wdata = 32'h11;
      lu_valid = 1'b1; lu_rd = 5'd9; lu_wdata = 32'h99;
      #1;
      chk("stv_c0_waddr", 32'(rf_waddr), 32'd1);
      tick();
      lu_rd = 5'd10; lu_wdata = 32'hAA;
      #1;
      chk("stv_c1_ready", 32'(lu_ready), 32'd1);
      chk("stv_c1_waddr", 32'(rf_waddr), 32'd1);
      tick();
      lu_valid = 1'b0;
      #1;
      chk("stv_full_ready", 32'(lu_ready), 32'd0);
      for (int i = 2; i <= 8; i++) begin
         chk("stv_nohold", 32'(wb_hold), 32'd0);
         chk("stv_wb_waddr", 32'(rf_waddr), 32'd1);
         tick();
         #1;
      end
      chk("stv_hold", 32'(wb_hold), 32'd1);
      chk("stv_hold_we", 32'(rf_we), 32'd1);
      chk("stv_hold_waddr", 32'(rf_waddr), 32'd9);
      chk("stv_hold_wdata", rf_wdata, 32'h99);
      tick();
      #1;
      chk("stv_hold_once", 32'(wb_hold), 32'd0);
      chk("stv_wb_resume", 32'(rf_waddr), 32'd1);
      chk("stv_resume_ready", 32'(lu_ready), 32'd1);
      tick();
      wb_regwrite = 1'b0;
      #1;
      chk("stv_tail_waddr", 32'(rf_waddr), 32'd10);
      chk("stv_tail_wdata", rf_wdata, 32'hAA);
      tick();
      #1;
      chk("stv_drained", 32'(rf_we), 32'd0);

      // Issue x7 in the same cycle as the pop of an older x7
      issue_valid = 1'b1; issue_rd = 5'd7;
      tick();
      issue_valid = 1'b0;
      lu_valid = 1'b1; lu_rd = 5'd7; lu_wdata = 32'h77;
      tick();
      lu_valid = 1'b0;
      issue_valid = 1'b1; issue_rd = 5'd7;
      #1;
      chk("x7_pop_waddr", 32'(rf_waddr), 32'd7);
      chk("x7_mask_pre", pending_mask, 32'h0000_0080);
      tick();
      issue_valid = 1'b0;
      #1;
      chk("x7_set_wins", pending_mask, 32'h0000_0080);
      lu_valid = 1'b1; lu_rd = 5'd7; lu_wdata = 32'h78;
      tick();
      lu_valid = 1'b0;
      tick();
      #1;
      chk("x7_cleared", pending_mask, 32'd0);

      // Killed WB write loses the port to the FIFO head
      lu_valid = 1'b1; lu_rd = 5'd4; lu_wdata = 32'h44;
      tick();
      lu_valid = 1'b0;
      wb_regwrite = 1'b1; wb_kill = 1'b1; wb_rd = 5'd3; wb_wdata = 32'h33;
      #1;
      chk("kill_we", 32'(rf_we), 32'd1);
      chk("kill_waddr", 32'(rf_waddr), 32'd4);
      chk("kill_wdata", rf_wdata, 32'h44);
      tick();
      #1;
      chk("kill_nowrite", 32'(rf_we), 32'd0);
      wb_kill = 1'b0; wb_rd = 5'd0;
      #1;
      chk("wb_x0_nowrite", 32'(rf_we), 32'd0);
      wb_regwrite = 1'b0;

      // LU result for x0 is accepted and dropped
      lu_valid = 1'b1; lu_rd = 5'd0; lu_wdata = 32'h1234;
      #1;
      chk("lu_x0_ready", 32'(lu_ready), 32'd1);
      tick();
      lu_valid = 1'b0;
      #1;
      chk("lu_x0_dropped", 32'(rf_we), 32'd0);

      // Reset while FIFO holds two entries
      wb_regwrite = 1'b1; wb_rd = 5'd2; wb_wdata = 32'h22;
      lu_valid = 1'b1; lu_rd = 5'd12; lu_wdata = 32'hC;
      issue_valid = 1'b1; issue_rd = 5'd13;
      tick();
      lu_rd = 5'd13; lu_wdata = 32'hD;
      issue_valid = 1'b0;
      tick();
      lu_valid = 1'b0;
      #1;
      chk("mid_full", 32'(lu_ready), 32'd0);
      chk("mid_mask", pending_mask, 32'h0000_2000);
      wb_regwrite = 1'b0;
      start = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(lu_ready), 32'd1);
      chk("mid_rst_mask", pending_mask, 32'd0);
      chk("mid_rst_we", 32'(rf_we), 32'd0);
      chk("mid_rst_hold", 32'(wb_hold), 32'd0);
      tick();
      start = 1'b1;
      tick();
      #1;
      chk("post_rst_empty", 32'(rf_we), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
